// File: rtl/aes_pkg.sv
// Shared AES constants: block/key widths, round-controller defaults,
// controller state encoding and the key-schedule round-constant table.
package aes_pkg;

  localparam int unsigned AesBlockW    = 128;
  localparam int unsigned AesKeyW      = 128;
  localparam int unsigned AesMaxRounds = 10;
  localparam int unsigned RoundW       = 4;
  localparam int unsigned RconW        = 8;

  localparam int unsigned DefNumRounds = 10;
  localparam int unsigned DefStageLat  = 3;

  typedef enum logic [1:0] {
    CtrlIdle  = 2'd0,
    CtrlInit  = 2'd1,
    CtrlRound = 2'd2,
    CtrlDone  = 2'd3
  } ctrlState_t;

  // Round constant for rounds 1..10; anything else yields 0x00.
  function automatic logic [RconW-1:0] rconLookup(input logic [RoundW-1:0] round);
    logic [RconW-1:0] rc;
    case (round)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1B;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/aes_rcon.sv
// Combinational round-constant lookup, shared by the round controller
// and the key-expansion logic.
module aes_rcon
  import aes_pkg::*;
(
  input  logic [RoundW-1:0] round,
  output logic [RconW-1:0]  rcon
);

  always_comb rcon = rconLookup(round);

endmodule

// File: rtl/aes_round_ctrl.sv
// Round sequencer for an iterative AES-128 datapath: load, NUM_ROUNDS rounds
// of STAGE_LAT stages each, then hold the ciphertext until it is taken.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned STAGE_LAT  = DefStageLat,
  parameter int unsigned NUM_ROUNDS = DefNumRounds
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              abort,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              load_en,
  output logic              stage_en,
  output logic [RoundW-1:0] round_idx,
  output logic [RconW-1:0]  rcon,
  output logic              last_round,
  output logic              busy
);

  localparam int unsigned       CntW      = (STAGE_LAT > 1) ? $clog2(STAGE_LAT) : 1;
  localparam logic [CntW-1:0]   CntLast   = CntW'(STAGE_LAT - 1);
  localparam logic [RoundW-1:0] RoundLast = RoundW'(NUM_ROUNDS);

  ctrlState_t        state, stateNext;
  logic [CntW-1:0]   stageCnt, stageCntNext;
  logic [RoundW-1:0] roundIdx, roundIdxNext;
  logic [RconW-1:0]  rconLut;

  logic              inReadyNext, outValidNext, loadEnNext, stageEnNext;
  logic              lastRoundNext, busyNext;
  logic [RconW-1:0]  rconNext;

  // Outputs are registered, so the constant is looked up for the next round.
  aes_rcon u_rcon (
    .round (roundIdxNext),
    .rcon  (rconLut)
  );

  always_comb begin
    stateNext    = state;
    stageCntNext = stageCnt;
    roundIdxNext = roundIdx;

    case (state)
      CtrlIdle: begin
        stageCntNext = '0;
        roundIdxNext = '0;
        if (in_valid) stateNext = CtrlInit;
      end
      CtrlInit: begin
        if (abort) begin
          stateNext = CtrlIdle;
        end else begin
          stateNext    = CtrlRound;
          roundIdxNext = RoundW'(1);
          stageCntNext = '0;
        end
      end
      CtrlRound: begin
        if (abort) begin
          stateNext    = CtrlIdle;
          roundIdxNext = '0;
          stageCntNext = '0;
        end else if (stageCnt == CntLast) begin
          stageCntNext = '0;
          if (roundIdx == RoundLast) stateNext = CtrlDone;
          else                       roundIdxNext = roundIdx + RoundW'(1);
        end else begin
          stageCntNext = stageCnt + CntW'(1);
        end
      end
      CtrlDone: begin
        // abort wins over out_ready; both return to idle without a new result
        if (abort || out_ready) begin
          stateNext    = CtrlIdle;
          roundIdxNext = '0;
        end
      end
      default: begin
        stateNext    = CtrlIdle;
        stageCntNext = '0;
        roundIdxNext = '0;
      end
    endcase

    inReadyNext   = (stateNext == CtrlIdle);
    busyNext      = (stateNext != CtrlIdle);
    loadEnNext    = (stateNext == CtrlInit);
    stageEnNext   = (stateNext == CtrlRound);
    outValidNext  = (stateNext == CtrlDone);
    lastRoundNext = (stateNext == CtrlRound) && (roundIdxNext == RoundLast);
    rconNext      = (stateNext == CtrlRound) ? rconLut : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= CtrlIdle;
      stageCnt   <= '0;
      roundIdx   <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      load_en    <= 1'b0;
      stage_en   <= 1'b0;
      rcon       <= '0;
      last_round <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= stateNext;
      stageCnt   <= stageCntNext;
      roundIdx   <= roundIdxNext;
      in_ready   <= inReadyNext;
      out_valid  <= outValidNext;
      load_en    <= loadEnNext;
      stage_en   <= stageEnNext;
      rcon       <= rconNext;
      last_round <= lastRoundNext;
      busy       <= busyNext;
    end
  end

  assign round_idx = roundIdx;

endmodule

// File: doc/aes_round_ctrl.md
AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 SHALL have parameter STAGE_LAT, default 3: register stages per round in the sequenced datapath (subBytes, shiftRow, mixColumns/addRoundKey); legal range 1..7.
REQ-002 SHALL have parameter NUM_ROUNDS, default 10: AES-128 round count; legal range 1..10.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: a new block (plaintext plus key) is presented to the datapath.
REQ-006 SHALL have port in_ready, output, 1 bit: the controller accepts a block.
REQ-007 SHALL have port abort, input, 1 bit: cancels the operation in flight.
REQ-008 SHALL have port out_valid, output, 1 bit: the datapath output holds the finished ciphertext.
REQ-009 SHALL have port out_ready, input, 1 bit: the consumer takes the ciphertext.
REQ-010 SHALL have port load_en, output, 1 bit: the datapath captures plaintext XOR key (round 0).
REQ-011 SHALL have port stage_en, output, 1 bit: advances the datapath and key-schedule registers.
REQ-012 SHALL have port round_idx, output, 4 bits: the current round number.
REQ-013 SHALL have port rcon, output, 8 bits: the round constant for the key schedule.
REQ-014 SHALL have port last_round, output, 1 bit: the datapath bypasses mixColumns.
REQ-015 SHALL have port busy, output, 1 bit: an operation is in flight.

Function
REQ-016 The FSM SHALL have the states IDLE, INIT, ROUND and DONE, with a stage counter stage_cnt of width clog2(STAGE_LAT).
REQ-017 In IDLE, in_ready SHALL be 1; in all other states, in_ready SHALL be 0, and in_valid SHALL be ignored.
REQ-018 IDLE SHALL go to INIT when in_valid and in_ready are both high; the handshake cycle is T.
REQ-019 INIT SHALL last exactly 1 cycle (T+1), with load_en=1, round_idx=0 and rcon=0x00, and SHALL then go to ROUND with round_idx=1 and stage_cnt=0.
REQ-020 In ROUND, stage_en SHALL be 1 every cycle, and stage_cnt SHALL increment each cycle.
REQ-021 In ROUND, at stage_cnt=STAGE_LAT-1, stage_cnt SHALL wrap to 0 and round_idx SHALL increment; if round_idx=NUM_ROUNDS, the FSM SHALL go to DONE instead.
REQ-022 In ROUND, rcon SHALL be a function of round_idx: 1..10 map to 01,02,04,08,10,20,40,80,1B,36 (hex).
REQ-023 rcon SHALL be 0x00 outside ROUND.
REQ-024 last_round SHALL equal 1 exactly when state=ROUND and round_idx=NUM_ROUNDS.
REQ-025 out_valid SHALL be 1 only in DONE; it is first asserted at cycle T+2+NUM_ROUNDS*STAGE_LAT (T+32 with defaults).
REQ-026 DONE SHALL hold out_valid, with stage_en=0, until out_ready=1, then go to IDLE; in_ready SHALL be 1 in the following cycle.
REQ-027 busy SHALL be 1 in every state except IDLE.
REQ-028 In IDLE and DONE, round_idx SHALL be 0 in IDLE and NUM_ROUNDS in DONE.
REQ-029 abort=1 in INIT, ROUND or DONE SHALL force IDLE on the next cycle, with no out_valid pulse.
REQ-030 abort SHALL take priority over out_ready when both are asserted in DONE.
REQ-031 abort SHALL be ignored in IDLE.
REQ-032 load_en and stage_en SHALL never both be 1 in the same cycle.

Reset
REQ-033 While rst=1, the block SHALL enter IDLE on the next edge, regardless of state, and reset SHALL override abort and every handshake.
REQ-034 Reset values SHALL be: in_ready=1, out_valid=0, load_en=0, stage_en=0, round_idx=0, rcon=0x00, last_round=0, busy=0, stage_cnt=0.
REQ-035 Reset mid-ROUND SHALL discard the operation, and no out_valid SHALL follow it.

Structure
REQ-036 The FSM state encodings, the default NUM_ROUNDS/STAGE_LAT values and the rcon table SHALL live in the shared AES package/header (aes_pkg), alongside existing AES constants.
REQ-037 The rcon lookup SHALL be a combinational sub-module aes_rcon (4-bit round in, 8-bit rcon out), which the key-expansion logic reuses.
REQ-038 All state, counters and registered outputs SHALL be in one clocked process, and all outputs SHALL be driven from registers or state decode, never directly from inputs.

Verification
REQ-039 Scenario: single block with defaults, in_valid pulse at cycle 5 and out_ready held 1 -> load_en at cycle 6, rcon 01..36 across cycles 7..36, last_round over cycles 34..36, out_valid at cycle 37 only, in_ready=1 at cycle 38.
REQ-040 Scenario: backpressure with out_ready=0 for 4 cycles after out_valid -> out_valid held for 5 cycles, stage_en=0 throughout, round_idx=10 stable.
REQ-041 Scenario: in_valid held 1 during busy -> in_ready=0, and no second INIT until after the DONE handshake.
REQ-042 Scenario: abort at round 4 (stage_cnt 1), then in the DONE state assert abort and out_ready together -> IDLE next cycle in both cases, and out_valid never rises in the first case.
REQ-043 Scenario: rst for 1 cycle mid-round 7 -> the reset values of REQ-034 on the next cycle; a new block then completes with normal latency.
REQ-044 Scenario: STAGE_LAT=1, NUM_ROUNDS=10 -> out_valid at T+12, with stage_en high for exactly 10 consecutive cycles.
